// File: rtl/hwpe_stream_zero_fifo_if.sv
// HWPE stream interface: valid/ready handshake carrying data and byte strobes.
// The monitor modport observes a stream without driving any of its signals.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );

    modport monitor (
        input valid, ready, data, strb
    );
endinterface

// File: rtl/hwpe_stream_zero_fifo.sv
// Zero-network shadow FIFO: buffers only valid/strb and checks itself against the normal FIFO.
// Define HWPE_STREAM_ZERO_FIFO_STICKY_FAULT_EN to latch faults until reset or clear.
module hwpe_stream_zero_fifo #(
    parameter int unsigned STRB_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    hwpe_stream_intf_stream.sink    push_i,
    hwpe_stream_intf_stream.source  pop_o,
    hwpe_stream_intf_stream.monitor normal_push_i,
    hwpe_stream_intf_stream.monitor normal_pop_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    fault_detected_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    logic [STRB_WIDTH-1:0] strb_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  empty, full;
    logic                  push_hs, pop_hs;
    logic                  mismatch;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntFull);

    assign empty_o      = empty;
    assign full_o       = full;
    assign push_i.ready = ~full;
    assign pop_o.valid  = ~empty;
    assign pop_o.strb   = strb_q[rd_ptr_q];

    assign push_hs = push_i.valid & ~full;
    assign pop_hs  = pop_o.ready & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_hs) begin
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop_hs) begin
                rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            end
            unique case ({push_hs, pop_hs})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                strb_q[i] <= '0;
            end
        end else if (push_hs && !clear_i) begin
            strb_q[wr_ptr_q] <= push_i.strb;
        end
    end

    // strb only matters while the output is valid
    assign mismatch = (~full != normal_push_i.ready)
                    | (~empty != normal_pop_i.valid)
                    | (~empty & (strb_q[rd_ptr_q] != normal_pop_i.strb));

`ifdef HWPE_STREAM_ZERO_FIFO_STICKY_FAULT_EN
    logic fault_q, fault_d;

    assign fault_d = clear_i ? 1'b0 : (fault_q | mismatch);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_detected_o = fault_q;
`else
    assign fault_detected_o = mismatch;
`endif

    logic unused_sigs;
    assign unused_sigs = ^{push_i.data, normal_push_i.valid, normal_push_i.data,
                           normal_push_i.strb, normal_pop_i.ready, normal_pop_i.data};
endmodule

// File: tb/tb_hwpe_stream_zero_fifo.sv
// Bench for hwpe_stream_zero_fifo: a queue stands in for the shadowed normal FIFO
// and doubles as the scoreboard for popped strobes.
module tb_hwpe_stream_zero_fifo;
    localparam int D  = 3;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic empty_o, full_o, fault_o;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(SW)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(SW)) pop ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(SW)) npush ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(SW)) npop ();

    hwpe_stream_zero_fifo #(.STRB_WIDTH(SW), .FIFO_DEPTH(D)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear),
        .push_i          (push),
        .pop_o           (pop),
        .normal_push_i   (npush),
        .normal_pop_i    (npop),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .fault_detected_o(fault_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [SW-1:0] q[$];
    logic          force_en = 1'b0;
    logic [SW-1:0] force_v = '0;

    // Behavioural normal FIFO outputs derived from the queue
    task automatic drive_normal();
        npush.valid = push.valid;
        npush.strb  = push.strb;
        npush.data  = '0;
        npush.ready = (q.size() < D);
        npop.valid  = (q.size() != 0);
        npop.strb   = force_en ? force_v : ((q.size() != 0) ? q[0] : '0);
        npop.ready  = pop.ready;
        npop.data   = '0;
    endtask

    task automatic step();
        bit ph, pp;
        logic [SW-1:0] ps;
        ph = push.valid && (q.size() < D);
        pp = pop.ready && (q.size() != 0);
        ps = push.strb;
        @(posedge clk);
        if (clear || rst) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (ph) q.push_back(ps);
        end
        #1;
        drive_normal();
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !clear && pop.valid === 1'b1 && pop.ready === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got strb %0h, expected no pop", pop.strb);
            end else if (pop.strb !== q[0]) begin
                n_fail++;
                $display("FAIL sb_strb: got %0h, expected %0h", pop.strb, q[0]);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        push.valid = 1'b0;
        push.strb = '0;
        push.data = '0;
        pop.ready = 1'b0;
        q.delete();
        drive_normal();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b, expected 1", empty_o); end
        n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b, expected 0", full_o); end
        n_chk++; if (push.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", push.ready); end
        n_chk++; if (pop.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", pop.valid); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, expected 0", fault_o); end
    endtask

    task automatic test_fill();
        logic [SW-1:0] vals [3];
        vals = '{4'hF, 4'h3, 4'h1};
        pop.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push.valid = 1'b1;
            push.strb = vals[i];
            drive_normal();
            step();
            if (i == 0) begin
                n_chk++; if (pop.valid !== 1'b1) begin n_fail++; $display("FAIL fill_latency: got %b, expected 1", pop.valid); end
            end
        end
        push.valid = 1'b0;
        drive_normal();
        #1;
        n_chk++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b, expected 1", full_o); end
        n_chk++; if (push.ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, expected 0", push.ready); end
        n_chk++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b, expected 0", empty_o); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL fill_fault: got %b, expected 0", fault_o); end
    endtask

    task automatic test_full_push_pop();
        push.valid = 1'b1;
        push.strb = 4'hA;
        pop.ready = 1'b1;
        drive_normal();
        #1;
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL fpp_fault_pre: got %b, expected 0", fault_o); end
        step();
        push.valid = 1'b0;
        pop.ready = 1'b0;
        drive_normal();
        #1;
        n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL fpp_full: got %b, expected 0", full_o); end
        n_chk++; if (push.ready !== 1'b1) begin n_fail++; $display("FAIL fpp_ready: got %b, expected 1", push.ready); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL fpp_fault: got %b, expected 0", fault_o); end
    endtask

    task automatic test_drain_wrap();
        logic [SW-1:0] vals [5];
        vals = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        pop.ready = 1'b1;
        push.valid = 1'b0;
        drive_normal();
        repeat (2) step();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b, expected 1", empty_o); end
        for (int i = 0; i < 5; i++) begin
            push.valid = 1'b1;
            push.strb = vals[i];
            drive_normal();
            step();
            n_chk++; if (pop.valid !== 1'b1) begin n_fail++; $display("FAIL tput_valid: got %b, expected 1", pop.valid); end
        end
        n_chk++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL tput_full: got %b, expected 0", full_o); end
        push.valid = 1'b0;
        drive_normal();
        step();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL tput_empty: got %b, expected 1", empty_o); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL tput_fault: got %b, expected 0", fault_o); end
        pop.ready = 1'b0;
        drive_normal();
    endtask

    task automatic test_clear();
        pop.ready = 1'b0;
        push.valid = 1'b1;
        push.strb = 4'h2;
        drive_normal();
        step();
        push.strb = 4'h4;
        drive_normal();
        step();
        push.strb = 4'hE;
        clear = 1'b1;
        drive_normal();
        step();
        clear = 1'b0;
        push.valid = 1'b0;
        drive_normal();
        #1;
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL clr_empty: got %b, expected 1", empty_o); end
        n_chk++; if (pop.valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b, expected 0", pop.valid); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL clr_fault: got %b, expected 0", fault_o); end
        push.valid = 1'b1;
        push.strb = 4'hC;
        drive_normal();
        step();
        push.valid = 1'b0;
        pop.ready = 1'b1;
        drive_normal();
        step();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL clr_after: got %b, expected 1", empty_o); end
        pop.ready = 1'b0;
        drive_normal();
    endtask

    task automatic test_fault();
        pop.ready = 1'b0;
        push.valid = 1'b1;
        push.strb = 4'h3;
        drive_normal();
        step();
        push.valid = 1'b0;
        force_en = 1'b1;
        force_v = 4'h7;
        drive_normal();
        #1;
`ifdef HWPE_STREAM_ZERO_FIFO_STICKY_FAULT_EN
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL flt_same: got %b, expected 0", fault_o); end
`else
        n_chk++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL flt_same: got %b, expected 1", fault_o); end
`endif
        step();
        force_en = 1'b0;
        drive_normal();
        #1;
`ifdef HWPE_STREAM_ZERO_FIFO_STICKY_FAULT_EN
        n_chk++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL flt_next: got %b, expected 1", fault_o); end
        step();
        n_chk++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL flt_hold: got %b, expected 1", fault_o); end
`else
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL flt_next: got %b, expected 0", fault_o); end
`endif
        clear = 1'b1;
        drive_normal();
        step();
        clear = 1'b0;
        drive_normal();
        #1;
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL flt_clear: got %b, expected 0", fault_o); end
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL flt_empty: got %b, expected 1", empty_o); end
    endtask

    task automatic test_async_reset();
        pop.ready = 1'b0;
        push.valid = 1'b1;
        push.strb = 4'h1;
        drive_normal();
        step();
        push.strb = 4'h2;
        drive_normal();
        step();
        push.valid = 1'b0;
        drive_normal();
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b, expected 1", empty_o); end
        n_chk++; if (pop.valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b, expected 0", pop.valid); end
        n_chk++; if (push.ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b, expected 1", push.ready); end
        q.delete();
        drive_normal();
        step();
        rst = 1'b0;
        push.valid = 1'b1;
        push.strb = 4'h9;
        drive_normal();
        step();
        push.valid = 1'b0;
        pop.ready = 1'b1;
        drive_normal();
        #1;
        n_chk++; if (pop.strb !== 4'h9) begin n_fail++; $display("FAIL arst_strb: got %0h, expected 9", pop.strb); end
        step();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL arst_after: got %b, expected 1", empty_o); end
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL arst_fault: got %b, expected 0", fault_o); end
        pop.ready = 1'b0;
        drive_normal();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_drain_wrap();
        test_clear();
        test_fault();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
